// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: streams words into imem from address 0
// and holds the core in reset until the final word has been written.
module imem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  input  logic                  reload,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  cpu_rst,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  overflow_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    DRAIN = 2'd1,
    RUN   = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic   accept;
  logic   at_last_addr;

  // Ready depends only on state and reset, so no path exists from s_valid.
  assign s_ready      = (state == LOAD) & ~rst;
  assign accept       = s_valid & s_ready;
  assign at_last_addr = (word_count == LAST_IDX);

  // NOTE: every variable assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD: begin
        if (accept) begin
          if (s_last)            state_nxt = DRAIN;
          else if (at_last_addr) state_nxt = ERR;
        end
      end
      DRAIN:   state_nxt = RUN;
      RUN:     if (reload) state_nxt = LOAD;
      ERR:     state_nxt = ERR;
      default: state_nxt = LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= LOAD;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_rst      <= 1'b1;
      done         <= 1'b0;
      word_count   <= '0;
      overflow_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      imem_we <= accept;
      if (accept) begin
        imem_addr  <= word_count[ADDR_WIDTH-1:0];
        imem_wdata <= s_data;
        word_count <= word_count + (ADDR_WIDTH + 1)'(1);
      end
      if (state == RUN && reload) word_count <= '0;
      // Core reset and done track the state being entered, keeping both glitch-free.
      cpu_rst <= (state_nxt != RUN);
      done    <= (state_nxt == RUN);
      if (state_nxt == ERR) overflow_err <= 1'b1;
    end
  end

endmodule
